lfsr_prbs_gen: RTL and testbench

Parametrised Fibonacci LFSR / PRBS generator, the successor to the fixed 16-bit LFSR. Width, tap polynomial, reset seed and shifts per clock are all parameters. Adds seed load with all-zero lock-up protection, a multi-bit per-clock output, and a wrap pulse when the sequence returns to its start state. It feeds the replay buffer's scrambling and test-pattern paths.

---
 rtl/lfsr_prbs_gen.sv | 86 ++++++++
 tb/tb_lfsr_prbs_gen.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/lfsr_prbs_gen.sv
// Parametrised Fibonacci LFSR / PRBS generator with seed load, zero-lock guard,
// multi-shift advance and a wrap pulse on return to the start reference state.

module lfsr_step #(
    parameter int               NBITS = 16,
    parameter logic [NBITS-1:0] TAPS  = 16'hB400
) (
    input  logic [NBITS-1:0] s,
    output logic [NBITS-1:0] s_next,
    output logic             fb
);
    assign fb     = ^(s & TAPS);
    assign s_next = {s[NBITS-2:0], fb};
endmodule

module lfsr_prbs_gen #(
    parameter int               NBITS = 16,
    parameter logic [NBITS-1:0] TAPS  = 16'hB400,
    parameter int               STEPS = 1,
    parameter logic [NBITS-1:0] SEED  = 16'h0001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [NBITS-1:0] data,
    input  logic             en,
    output logic [NBITS-1:0] q,
    output logic [STEPS-1:0] bit_out,
    output logic             valid,
    output logic             lockup,
    output logic             wrap
);
    // Start-of-sequence reference; wrap fires when an advance lands back on it.
    logic [NBITS-1:0]            ref_q;
    logic [STEPS:0][NBITS-1:0]   chain;
    logic [STEPS-1:0]            fb_vec;
    logic [NBITS-1:0]            adv;
    logic                        load_zero;

    assign chain[0]  = q;
    assign adv       = chain[STEPS];
    assign load_zero = (data == '0);

    // STEPS single shifts chained combinationally; stage k yields bit_out[k].
    for (genvar k = 0; k < STEPS; k++) begin : g_step
        lfsr_step #(
            .NBITS (NBITS),
            .TAPS  (TAPS)
        ) u_step (
            .s      (chain[k]),
            .s_next (chain[k+1]),
            .fb     (fb_vec[k])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q       <= SEED;
            ref_q   <= SEED;
            bit_out <= '0;
            valid   <= 1'b0;
            lockup  <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            valid  <= 1'b0;
            lockup <= 1'b0;
            wrap   <= 1'b0;
            if (we) begin
                // A zero load would lock the register; substitute SEED instead.
                if (load_zero) begin
                    q      <= SEED;
                    ref_q  <= SEED;
                    lockup <= 1'b1;
                end else begin
                    q      <= data;
                    ref_q  <= data;
                end
            end else if (en) begin
                q       <= adv;
                bit_out <= fb_vec;
                valid   <= 1'b1;
                wrap    <= (adv == ref_q);
            end
        end
    end
endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// Bench for lfsr_prbs_gen: scoreboarded STEPS=1 instance plus STEPS=4 and a
// second STEPS=1 instance used for the loaded-seed wrap check.

module tb_lfsr_prbs_gen;
    typedef struct packed {
        logic [15:0] q;
        logic        bo;
        logic        valid;
        logic        lockup;
        logic        wrap;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic        we1 = 1'b0, en1 = 1'b0;
    logic [15:0] data1 = '0;
    logic [15:0] q1;
    logic [0:0]  bo1;
    logic        valid1, lockup1, wrap1;

    logic        we2 = 1'b0, en2 = 1'b0;
    logic [15:0] data2 = '0;
    logic [15:0] q2;
    logic [0:0]  bo2;
    logic        valid2, lockup2, wrap2;

    logic        we4 = 1'b0, en4 = 1'b0;
    logic [15:0] data4 = '0;
    logic [15:0] q4;
    logic [3:0]  bo4;
    logic        valid4, lockup4, wrap4;

    int tests = 0;
    int fails = 0;
    exp_t sbq[$];
    logic [15:0] m_q = 16'h0001, m_ref = 16'h0001;
    logic        m_bit = 1'b0;

    always #5 clk = ~clk;

    lfsr_prbs_gen #(.NBITS(16), .TAPS(16'hB400), .STEPS(1), .SEED(16'h0001)) u1 (
        .clk(clk), .rst(rst), .we(we1), .data(data1), .en(en1),
        .q(q1), .bit_out(bo1), .valid(valid1), .lockup(lockup1), .wrap(wrap1));

    lfsr_prbs_gen #(.NBITS(16), .TAPS(16'hB400), .STEPS(1), .SEED(16'h0001)) u2 (
        .clk(clk), .rst(rst), .we(we2), .data(data2), .en(en2),
        .q(q2), .bit_out(bo2), .valid(valid2), .lockup(lockup2), .wrap(wrap2));

    lfsr_prbs_gen #(.NBITS(16), .TAPS(16'hB400), .STEPS(4), .SEED(16'h0001)) u4 (
        .clk(clk), .rst(rst), .we(we4), .data(data4), .en(en4),
        .q(q4), .bit_out(bo4), .valid(valid4), .lockup(lockup4), .wrap(wrap4));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive u1 for one clock; expected outcome is queued before the edge, popped after.
    task automatic drive1(input logic w, input logic [15:0] d, input logic e);
        exp_t x;
        logic fb;
        we1 = w; data1 = d; en1 = e;
        x = '0;
        if (w) begin
            if (d == 16'h0000) begin
                m_q = 16'h0001; m_ref = 16'h0001; x.lockup = 1'b1;
            end else begin
                m_q = d; m_ref = d;
            end
        end else if (e) begin
            fb = m_q[15] ^ m_q[13] ^ m_q[12] ^ m_q[10];
            m_q = {m_q[14:0], fb};
            m_bit = fb;
            x.valid = 1'b1;
            x.wrap = (m_q == m_ref);
        end
        x.q = m_q;
        x.bo = m_bit;
        sbq.push_back(x);
        @(posedge clk); #1;
        x = sbq.pop_front();
        chk("sb_q", q1, x.q);
        chk("sb_bit_out", bo1, x.bo);
        chk("sb_valid", valid1, x.valid);
        chk("sb_lockup", lockup1, x.lockup);
        chk("sb_wrap", wrap1, x.wrap);
    endtask

    initial begin
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q", q1, 16'h0001);
        chk("rst_bit_out", bo1, 1'b0);
        chk("rst_valid", valid1, 1'b0);
        chk("rst_lockup", lockup1, 1'b0);
        chk("rst_wrap", wrap1, 1'b0);
        chk("rst_q4", q4, 16'h0001);
        rst = 1'b1;

        // STEPS=4 instance: four shifts per clock
        en4 = 1'b1;
        @(posedge clk); #1;
        chk("s4_q1", q4, 16'h0010);
        chk("s4_bo1", bo4, 4'b0000);
        chk("s4_valid", valid4, 1'b1);
        @(posedge clk); #1;
        chk("s4_q2", q4, 16'h0100);
        @(posedge clk); #1;
        chk("s4_q3", q4, 16'h1002);
        chk("s4_bo3", bo4, 4'b0100);
        en4 = 1'b0;
        @(posedge clk); #1;
        chk("s4_hold_valid", valid4, 1'b0);
        chk("s4_hold_q", q4, 16'h1002);

        // First advances from reset
        drive1(1'b0, 16'h0000, 1'b1);
        chk("adv1_q", q1, 16'h0002);
        chk("adv1_valid", valid1, 1'b1);
        chk("adv1_wrap", wrap1, 1'b0);
        repeat (9) drive1(1'b0, 16'h0000, 1'b1);
        chk("adv10_q", q1, 16'h0400);
        drive1(1'b0, 16'h0000, 1'b1);
        chk("adv11_q", q1, 16'h0801);
        chk("adv11_bo", bo1, 1'b1);

        // Zero load -> SEED with lockup; u2 takes seed 0x1234 on the same edge
        we2 = 1'b1; data2 = 16'h1234;
        drive1(1'b1, 16'h0000, 1'b0);
        chk("lock_q", q1, 16'h0001);
        chk("lock_pulse", lockup1, 1'b1);
        chk("lock_valid", valid1, 1'b0);
        chk("u2_load_q", q2, 16'h1234);
        we2 = 1'b0;
        drive1(1'b0, 16'h0000, 1'b0);
        chk("lock_clear", lockup1, 1'b0);

        // Load beats advance
        drive1(1'b1, 16'hACE1, 1'b1);
        chk("ldwin_q", q1, 16'hACE1);
        chk("ldwin_valid", valid1, 1'b0);
        drive1(1'b0, 16'hACE1, 1'b0);
        chk("hold_q", q1, 16'hACE1);

        // Back to SEED reference, then a full period on u1 and u2 in parallel
        drive1(1'b1, 16'h0000, 1'b0);
        en2 = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            drive1(1'b0, 16'h0000, 1'b1);
            chk("wrap1_period", wrap1, (i == 65534));
            chk("wrap2_period", wrap2, (i == 65534));
        end
        en2 = 1'b0;
        chk("wrap1_q", q1, 16'h0001);
        chk("wrap2_q", q2, 16'h1234);

        // Asynchronous reset mid-stream with en held high
        repeat (3) drive1(1'b0, 16'h0000, 1'b1);
        en1 = 1'b1;
        #3;
        rst = 1'b0;
        #1;
        chk("arst_q", q1, 16'h0001);
        chk("arst_valid", valid1, 1'b0);
        chk("arst_bo", bo1, 1'b0);
        chk("arst_lockup", lockup1, 1'b0);
        chk("arst_wrap", wrap1, 1'b0);
        m_q = 16'h0001; m_ref = 16'h0001; m_bit = 1'b0;
        @(posedge clk); #1;
        chk("arst_hold_q", q1, 16'h0001);
        chk("arst_hold_valid", valid1, 1'b0);
        rst = 1'b1;
        drive1(1'b0, 16'h0000, 1'b1);
        chk("restart_q", q1, 16'h0002);
        chk("restart_bo", bo1, 1'b0);
        repeat (10) drive1(1'b0, 16'h0000, 1'b1);
        chk("restart_q11", q1, 16'h0801);
        en1 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
